// File: rtl/dispatch_nw_if.sv
// dispatch_nw_if: instruction/ROB-entry types and the Rename-to-backend dispatch bus.
package dispatch_nw_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        has_rd;
        logic [5:0]  prd;
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic        is_load;
        logic        is_store;
        logic        is_muldiv;
        logic        is_branch;
        logic        is_jump;
    } renamed_inst_t;

    typedef struct packed {
        logic        is_valid;
        logic        is_ready;
        logic        has_exception;
        logic [3:0]  exc_cause;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        has_rd;
        logic        is_branch;
        logic        is_jump;
        logic        is_store;
    } rob_entry_t;
endpackage

interface dispatch_nw_if #(
    parameter int WIDTH       = 2,
    parameter int ROB_IDX_W   = 5,
    parameter int CNT_W       = $clog2(WIDTH+1),
    parameter int STALL_CNT_W = 32
) ();
    logic                                    flush;
    logic [ROB_IDX_W:0]                      flush_tail;
    logic                                    in_valid;
    logic                                    in_ready;
    dispatch_nw_pkg::renamed_inst_t [WIDTH-1:0] in_inst;
    logic [CNT_W-1:0]                        alu_free;
    logic [CNT_W-1:0]                        mdu_free;
    logic [CNT_W-1:0]                        lsq_free;
    logic [CNT_W-1:0]                        rob_free;
    logic [WIDTH-1:0]                        alu_we;
    logic [WIDTH-1:0]                        mdu_we;
    logic [WIDTH-1:0]                        lsq_we;
    dispatch_nw_pkg::renamed_inst_t [WIDTH-1:0] alu_entry;
    dispatch_nw_pkg::renamed_inst_t [WIDTH-1:0] mdu_entry;
    dispatch_nw_pkg::renamed_inst_t [WIDTH-1:0] lsq_entry;
    logic [WIDTH-1:0][ROB_IDX_W:0]           alu_tag;
    logic [WIDTH-1:0][ROB_IDX_W:0]           mdu_tag;
    logic [WIDTH-1:0][ROB_IDX_W:0]           lsq_tag;
    logic [WIDTH-1:0]                        rob_we;
    dispatch_nw_pkg::rob_entry_t [WIDTH-1:0] rob_entry;
    logic [STALL_CNT_W-1:0]                  stall_cycles;

    modport slave (
        input  flush, flush_tail, in_valid, in_inst, alu_free, mdu_free, lsq_free, rob_free,
        output in_ready, alu_we, mdu_we, lsq_we, alu_entry, mdu_entry, lsq_entry,
               alu_tag, mdu_tag, lsq_tag, rob_we, rob_entry, stall_cycles
    );
    modport master (
        output flush, flush_tail, in_valid, in_inst, alu_free, mdu_free, lsq_free, rob_free,
        input  in_ready, alu_we, mdu_we, lsq_we, alu_entry, mdu_entry, lsq_entry,
               alu_tag, mdu_tag, lsq_tag, rob_we, rob_entry, stall_cycles
    );
endinterface

// File: rtl/dispatch_nw.sv
// dispatch_nw: registered WIDTH-wide dispatch of the longest in-order prefix that fits queue/ROB credits.
module dispatch_nw import dispatch_nw_pkg::*; #(
    parameter int WIDTH       = 2,
    parameter int ROB_DEPTH   = 32,
    parameter int ROB_IDX_W   = $clog2(ROB_DEPTH),
    parameter int CNT_W       = $clog2(WIDTH+1),
    parameter int STALL_CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dispatch_nw_if.slave  bus
);
    localparam int TAG_W = ROB_IDX_W + 1;
    localparam int IW    = $bits(renamed_inst_t);

    renamed_inst_t [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0]          hv_q;
    logic [WIDTH-1:0]          in_v;
    logic [TAG_W-1:0]          tail_q;
    logic [TAG_W-1:0]          tag;
    logic [STALL_CNT_W-1:0]    stall_q;
    logic [CNT_W-1:0]          d;
    logic                      is_lsq;
    logic                      is_mdu;
    logic                      fits;
    logic                      stop;
    rob_entry_t                re;
    int                        na;
    int                        nm;
    int                        nl;
    int                        nd;

    always_comb begin
        bus.alu_we = '0;
        bus.mdu_we = '0;
        bus.lsq_we = '0;
        bus.rob_we = '0;
        bus.alu_entry = '0;
        bus.mdu_entry = '0;
        bus.lsq_entry = '0;
        bus.alu_tag = '0;
        bus.mdu_tag = '0;
        bus.lsq_tag = '0;
        bus.rob_entry = '0;
        is_lsq = 1'b0;
        is_mdu = 1'b0;
        fits = 1'b0;
        stop = 1'b0;
        tag = '0;
        re = '0;
        na = 0;
        nm = 0;
        nl = 0;
        nd = 0;
        for (int k = 0; k < WIDTH; k++) begin
            in_v[k] = bus.in_inst[k].valid;
            is_lsq = hold_q[k].is_load || hold_q[k].is_store;
            is_mdu = !is_lsq && hold_q[k].is_muldiv;
            fits = is_lsq ? (nl < int'(bus.lsq_free)) : is_mdu ? (nm < int'(bus.mdu_free)) : (na < int'(bus.alu_free));
            // Once one slot fails, no younger slot may bypass it.
            if (!stop && !bus.flush && hv_q[k] && nd < int'(bus.rob_free) && fits) begin
                tag = tail_q + TAG_W'(k);
                re = '0;
                re.is_valid = 1'b1;
                re.pc = hold_q[k].pc;
                re.rd = hold_q[k].rd;
                re.has_rd = hold_q[k].has_rd;
                re.is_branch = hold_q[k].is_branch;
                re.is_jump = hold_q[k].is_jump;
                re.is_store = hold_q[k].is_store;
                bus.rob_we[k] = 1'b1;
                bus.rob_entry[k] = re;
                if (is_lsq) begin
                    bus.lsq_we[nl] = 1'b1;
                    bus.lsq_entry[nl] = hold_q[k];
                    bus.lsq_tag[nl] = tag;
                    nl++;
                end else if (is_mdu) begin
                    bus.mdu_we[nm] = 1'b1;
                    bus.mdu_entry[nm] = hold_q[k];
                    bus.mdu_tag[nm] = tag;
                    nm++;
                end else begin
                    bus.alu_we[na] = 1'b1;
                    bus.alu_entry[na] = hold_q[k];
                    bus.alu_tag[na] = tag;
                    na++;
                end
                nd++;
            end else begin
                stop = 1'b1;
            end
        end
        d = CNT_W'(nd);
        bus.in_ready = !bus.flush && ($countones(hv_q) == nd);
        bus.stall_cycles = stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            hv_q <= '0;
            tail_q <= '0;
            stall_q <= '0;
        end else if (bus.flush) begin
            hv_q <= '0;
            tail_q <= bus.flush_tail;
        end else begin
            tail_q <= tail_q + TAG_W'(d);
            stall_q <= (|hv_q && d == '0 && stall_q != '1) ? stall_q + STALL_CNT_W'(1) : stall_q;
            if (bus.in_valid && bus.in_ready) begin
                hold_q <= bus.in_inst;
                hv_q <= in_v;
            end else begin
                // Undispatched slots slide down so slot 0 stays the oldest.
                hold_q <= hold_q >> (IW * nd);
                hv_q <= hv_q >> d;
            end
        end
    end
endmodule

// File: tb/tb_dispatch_nw.sv
// tb_dispatch_nw: randomized and directed bench for dispatch_nw with a queue-based in-order reference model.
module tb_dispatch_nw;
    import dispatch_nw_pkg::*;
    localparam int W = 2, DEPTH = 32, IW = 5, TW = IW + 1, CW = $clog2(W + 1);
    typedef renamed_inst_t [W-1:0] bundle_t;
    typedef struct { renamed_inst_t inst; int tag; } held_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    dispatch_nw_if #(.WIDTH(W), .ROB_IDX_W(IW)) bus ();
    dispatch_nw #(.WIDTH(W), .ROB_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    held_t  held[$];
    int     next_tag = 0;
    int     checks = 0, errors = 0;
    longint exp_stall = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic int cls(renamed_inst_t i);
        return (i.is_load || i.is_store) ? 2 : (i.is_muldiv ? 1 : 0);
    endfunction

    // c: 0 alu, 1 mdu, 2 load, 3 store; memory ops may also carry is_muldiv to exercise precedence
    function automatic renamed_inst_t rnd_inst(int c);
        renamed_inst_t i;
        i = '0;
        i.valid = 1'b1;
        i.pc = $urandom;
        i.rd = 5'($urandom);
        i.has_rd = 1'($urandom);
        i.prd = 6'($urandom);
        i.prs1 = 6'($urandom);
        i.prs2 = 6'($urandom);
        i.is_load = (c == 2);
        i.is_store = (c == 3);
        i.is_muldiv = (c == 1) || (c >= 2 && $urandom_range(0, 1) == 1);
        i.is_branch = (c == 0) && $urandom_range(0, 3) == 0;
        i.is_jump = (c == 0) && $urandom_range(0, 3) == 0;
        return i;
    endfunction

    function automatic bundle_t mk(int c0, int c1);
        bundle_t b;
        b = '0;
        if (c0 >= 0) b[0] = rnd_inst(c0);
        if (c1 >= 0) b[1] = rnd_inst(c1);
        return b;
    endfunction

    task automatic step(input logic fl, input int ft, input logic v, input bundle_t b,
                        input int af, input int mf, input int lf, input int rf);
        logic acc;
        bus.flush = fl;
        bus.flush_tail = TW'(ft);
        bus.in_valid = v;
        bus.in_inst = b;
        bus.alu_free = CW'(af);
        bus.mdu_free = CW'(mf);
        bus.lsq_free = CW'(lf);
        bus.rob_free = CW'(rf);
        @(negedge clk);
        acc = v && bus.in_ready;
        @(posedge clk);
        #1;
        if (fl) begin
            held.delete();
            next_tag = ft;
        end else if (acc) begin
            for (int k = 0; k < W; k++)
                if (b[k].valid) begin
                    held.push_back('{b[k], next_tag});
                    next_tag = (next_tag + 1) % (2 * DEPTH);
                end
        end
    endtask

    task automatic idle(input int rf);
        step(1'b0, 0, 1'b0, '0, W, W, W, rf);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        held.delete();
        next_tag = 0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: derives the expected dispatch from the model's held instructions and the live credits.
    always @(negedge clk) begin : mon
        int d, c;
        int cnt[3];
        int fr[3];
        logic [W-1:0] m[3];
        rob_entry_t re;
        renamed_inst_t ae;
        logic [TW-1:0] at;
        if (!rst_n) exp_stall = 0;
        fr = '{int'(bus.alu_free), int'(bus.mdu_free), int'(bus.lsq_free)};
        cnt = '{0, 0, 0};
        m[0] = '0; m[1] = '0; m[2] = '0;
        d = 0;
        if (rst_n && !bus.flush)
            for (int i = 0; i < held.size(); i++) begin
                c = cls(held[i].inst);
                if (d >= int'(bus.rob_free) || cnt[c] >= fr[c]) break;
                re = '0;
                re.is_valid = 1'b1;
                re.pc = held[i].inst.pc;
                re.rd = held[i].inst.rd;
                re.has_rd = held[i].inst.has_rd;
                re.is_branch = held[i].inst.is_branch;
                re.is_jump = held[i].inst.is_jump;
                re.is_store = held[i].inst.is_store;
                chk($sformatf("rob_entry%0d", d), 64'(bus.rob_entry[d]), 64'(re));
                ae = (c == 0) ? bus.alu_entry[cnt[c]] : (c == 1) ? bus.mdu_entry[cnt[c]] : bus.lsq_entry[cnt[c]];
                at = (c == 0) ? bus.alu_tag[cnt[c]] : (c == 1) ? bus.mdu_tag[cnt[c]] : bus.lsq_tag[cnt[c]];
                chk($sformatf("q%0d_entry%0d", c, cnt[c]), 64'(ae), 64'(held[i].inst));
                chk($sformatf("q%0d_tag%0d", c, cnt[c]), 64'(at), 64'(held[i].tag));
                m[c][cnt[c]] = 1'b1;
                cnt[c]++;
                d++;
            end
        chk("rob_we", 64'(bus.rob_we), (64'd1 << d) - 64'd1);
        chk("alu_we", 64'(bus.alu_we), 64'(m[0]));
        chk("mdu_we", 64'(bus.mdu_we), 64'(m[1]));
        chk("lsq_we", 64'(bus.lsq_we), 64'(m[2]));
        chk("in_ready", 64'(bus.in_ready), 64'(!bus.flush && d == held.size()));
        chk("stall_cycles", 64'(bus.stall_cycles), 64'(exp_stall));
        if (rst_n && !bus.flush && held.size() > 0 && d == 0 && exp_stall != 64'hffffffff) exp_stall++;
        repeat (d) void'(held.pop_front());
    end

    initial begin
        bus.flush = 1'b0;
        bus.flush_tail = '0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.alu_free = CW'(W);
        bus.mdu_free = CW'(W);
        bus.lsq_free = CW'(W);
        bus.rob_free = CW'(W);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 0, 1'b1, mk(0, 0), 2, 2, 2, 2);
        idle(2);
        step(1'b0, 0, 1'b1, mk(0, 1), 2, 2, 2, 2);
        step(1'b0, 0, 1'b0, '0, 2, 0, 2, 2);
        step(1'b0, 0, 1'b0, '0, 2, 1, 2, 2);
        step(1'b0, 0, 1'b1, mk(3, 2), 2, 2, 2, 2);
        step(1'b0, 0, 1'b0, '0, 2, 2, 1, 2);
        step(1'b0, 0, 1'b0, '0, 2, 2, 1, 2);
        step(1'b1, 31, 1'b0, '0, 2, 2, 2, 2);
        step(1'b0, 0, 1'b1, mk(0, 2), 2, 2, 2, 2);
        idle(2);
        step(1'b0, 0, 1'b1, mk(0, 1), 2, 2, 2, 2);
        idle(2);
        step(1'b0, 0, 1'b1, mk(0, 1), 2, 2, 2, 2);
        repeat (5) idle(0);
        step(1'b1, 36, 1'b0, '0, 2, 2, 2, 2);
        step(1'b0, 0, 1'b1, mk(0, -1), 2, 2, 2, 2);
        idle(2);
        step(1'b0, 0, 1'b1, mk(1, 2), 2, 2, 2, 2);
        idle(0);
        do_reset();
        step(1'b0, 0, 1'b1, mk(0, -1), 2, 2, 2, 2);
        idle(2);
        for (int n = 0; n < 2000; n++) begin
            bundle_t b;
            int nv;
            b = '0;
            nv = $urandom_range(0, W);
            for (int k = 0; k < nv; k++) b[k] = rnd_inst($urandom_range(0, 3));
            step($urandom_range(0, 29) == 0, $urandom_range(0, 2 * DEPTH - 1), $urandom_range(0, 3) != 0, b,
                 $urandom_range(0, W), $urandom_range(0, W), $urandom_range(0, W), $urandom_range(0, W));
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
